obs_l4_submul_scheduler: RTL and testbench

Sequencing controller for one 24x24-bit GF(2) polynomial multiplication, built by odd/even (OBS) splitting. It splits each 24-bit operand into 12-bit even and odd coefficient halves and time-shares a single external 12x12 GF(2) sub-multiplier across the four half-products. It collects the four 23-bit results by tag, recombines them into the 47-bit product with an internal instance of `overlap_module_24bit`, and presents the product on a valid/ready output port.

---
 rtl/obs_l4_submul_scheduler.sv | 169 ++++++++++++++++
 tb/tb_obs_l4_submul_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/obs_l4_submul_scheduler.sv
// rtl/obs_l4_submul_scheduler.sv - OBS-split 24x24 GF(2) multiply sequencer around one shared 12x12 sub-multiplier
// Half-products are collected by tag and recombined by overlap_module_24bit.

module overlap_module_24bit (
  input  logic [22:0] in1,
  input  logic [22:0] in2,
  input  logic [22:0] in3,
  input  logic [22:0] in4,
  output logic [46:0] p
);
  // Even terms interleave Ae*Be with the x^2-shifted Ao*Bo; odd terms are the two cross products.
  always_comb begin
    p = '0;
    p[0]  = in1[0];
    p[46] = in4[22];
    for (int i = 1; i < 23; i++) begin
      p[2*i] = in1[i] ^ in4[i-1];
    end
    for (int i = 0; i < 23; i++) begin
      p[2*i+1] = in2[i] ^ in3[i];
    end
  end
endmodule

module obs_l4_submul_scheduler #(
  parameter int N   = 24,
  parameter int TMO = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic         sm_req_valid,
  input  logic         sm_req_ready,
  output logic [11:0]  sm_a,
  output logic [11:0]  sm_b,
  output logic [1:0]   sm_tag,
  input  logic         sm_rsp_valid,
  input  logic [1:0]   sm_rsp_tag,
  input  logic [22:0]  sm_rsp_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [46:0]  p_out,
  output logic         busy,
  output logic         err_dup,
  output logic         err_tmo
);
  localparam int TW = (TMO > 0) ? $clog2(TMO + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  state_t state, state_nxt;

  logic [11:0]       ae, ao, be, bo;
  logic [11:0]       ae_in, ao_in, be_in, bo_in;
  logic [1:0]        ic, ic_inc;
  logic [3:0]        got, got_nxt;
  logic [3:0][22:0]  r, r_nxt;
  logic [TW-1:0]     wd;
  logic [46:0]       p_comb;
  logic              accept, req_hs, last_hs, rsp_take, all_got, wd_fire;

  always_comb begin
    for (int i = 0; i < 12; i++) begin
      ae_in[i] = a_in[2*i];
      ao_in[i] = a_in[2*i+1];
      be_in[i] = b_in[2*i];
      bo_in[i] = b_in[2*i+1];
    end
  end

  assign accept   = in_valid && (state == S_IDLE);
  assign req_hs   = sm_req_valid && sm_req_ready;
  assign last_hs  = req_hs && (ic == 2'd3);
  assign ic_inc   = ic + 2'd1;
  assign rsp_take = sm_rsp_valid && (state == S_ISSUE || state == S_WAIT) && !got[sm_rsp_tag];

  // Fold the same-cycle response in so the product can be registered on the edge that completes it.
  always_comb begin
    r_nxt   = r;
    got_nxt = got;
    if (rsp_take) begin
      r_nxt[sm_rsp_tag]   = sm_rsp_data;
      got_nxt[sm_rsp_tag] = 1'b1;
    end
  end

  assign all_got = &got_nxt;
  assign wd_fire = (TMO != 0) && (state == S_WAIT) && !sm_rsp_valid && (wd == TW'(TMO - 1));

  overlap_module_24bit u_comb (
    .in1 (r_nxt[0]),
    .in2 (r_nxt[1]),
    .in3 (r_nxt[2]),
    .in4 (r_nxt[3]),
    .p   (p_comb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      S_ISSUE: if (last_hs) state_nxt = all_got ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (all_got)      state_nxt = S_DONE;
        else if (wd_fire) state_nxt = S_IDLE;
      end
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign sm_tag    = ic;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ae           <= '0;
      ao           <= '0;
      be           <= '0;
      bo           <= '0;
      ic           <= '0;
      sm_req_valid <= 1'b0;
      sm_a         <= '0;
      sm_b         <= '0;
      got          <= '0;
      r            <= '0;
      wd           <= '0;
      p_out        <= '0;
      err_dup      <= 1'b0;
      err_tmo      <= 1'b0;
    end else begin
      r   <= r_nxt;
      got <= got_nxt;
      if (sm_rsp_valid && !rsp_take) err_dup <= 1'b1;
      if (wd_fire)                   err_tmo <= 1'b1;
      wd <= (state == S_WAIT && !sm_rsp_valid) ? wd + TW'(1) : '0;
      if (accept) begin
        ae           <= ae_in;
        ao           <= ao_in;
        be           <= be_in;
        bo           <= bo_in;
        ic           <= 2'd0;
        got          <= 4'd0;
        sm_req_valid <= 1'b1;
        sm_a         <= ae_in;
        sm_b         <= be_in;
      end else if (req_hs) begin
        // Tag bit 1 selects the odd A half, tag bit 0 the odd B half.
        if (ic == 2'd3) begin
          sm_req_valid <= 1'b0;
        end else begin
          ic   <= ic_inc;
          sm_a <= ic_inc[1] ? ao : ae;
          sm_b <= ic_inc[0] ? bo : be;
        end
      end
      if (state_nxt == S_DONE && state != S_DONE) p_out <= p_comb;
    end
  end
endmodule

// File: tb/tb_obs_l4_submul_scheduler.sv
// tb/tb_obs_l4_submul_scheduler.sv - randomized and directed bench for obs_l4_submul_scheduler
// Reference: full carry-less 24x24 multiply plus a latency-randomized sub-multiplier responder.

module tb_obs_l4_submul_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready;
  logic [23:0] a_in, b_in;
  logic        sm_req_valid, sm_req_ready;
  logic [11:0] sm_a, sm_b;
  logic [1:0]  sm_tag;
  logic        sm_rsp_valid;
  logic [1:0]  sm_rsp_tag;
  logic [22:0] sm_rsp_data;
  logic        out_valid, out_ready;
  logic [46:0] p_out;
  logic        busy, err_dup, err_tmo;

  obs_l4_submul_scheduler #(.N(24), .TMO(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .sm_req_valid(sm_req_valid), .sm_req_ready(sm_req_ready),
    .sm_a(sm_a), .sm_b(sm_b), .sm_tag(sm_tag), .sm_rsp_valid(sm_rsp_valid),
    .sm_rsp_tag(sm_rsp_tag), .sm_rsp_data(sm_rsp_data), .out_valid(out_valid),
    .out_ready(out_ready), .p_out(p_out), .busy(busy), .err_dup(err_dup), .err_tmo(err_tmo)
  );

  int          n_cmp = 0, n_fail = 0, cyc = 0, n_done = 0, dly_max = 1;
  bit          rnd_mode = 0, exp_have = 0, prev_stall = 0, seen_out = 0;
  logic [3:0]  hold_mask = 4'd0;
  bit          pend_v[4];
  int          pend_due[4];
  logic [22:0] pend_d[4];
  logic [23:0] cur_a, cur_b;
  logic [46:0] exp_p;
  int          exp_tag = 0;
  logic [11:0] prev_a, prev_b;
  logic [1:0]  prev_tag;
  logic [1:0]  log_tag[$];
  logic [11:0] log_a[$], log_b[$];

  function automatic logic [46:0] clmul24(input logic [23:0] a, input logic [23:0] b);
    logic [46:0] p = '0;
    for (int i = 0; i < 24; i++) if (b[i]) p ^= 47'(a) << i;
    return p;
  endfunction

  function automatic logic [22:0] clmul12(input logic [11:0] a, input logic [11:0] b);
    logic [22:0] p = '0;
    for (int i = 0; i < 12; i++) if (b[i]) p ^= 23'(a) << i;
    return p;
  endfunction

  function automatic logic [11:0] half(input logic [23:0] x, input bit odd);
    logic [11:0] h;
    for (int i = 0; i < 12; i++) h[i] = x[2*i + int'(odd)];
    return h;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the transaction-level model; also records handshakes.
  task automatic compare_cycle();
    if (!rst_n) begin
      exp_have = 0; exp_tag = 0; prev_stall = 0;
      for (int t = 0; t < 4; t++) pend_v[t] = 0;
      return;
    end
    check("in_ready_not_busy", 64'(in_ready), 64'(!busy));
    if (sm_req_valid) begin
      check("req_tag", 64'(sm_tag), 64'(exp_tag));
      check("req_a", 64'(sm_a), 64'(half(cur_a, exp_tag >= 2)));
      check("req_b", 64'(sm_b), 64'(half(cur_b, (exp_tag % 2) == 1)));
      if (prev_stall) check("req_stall_hold", 64'({sm_tag, sm_a, sm_b}), 64'({prev_tag, prev_a, prev_b}));
    end
    prev_stall = sm_req_valid && !sm_req_ready;
    prev_a = sm_a; prev_b = sm_b; prev_tag = sm_tag;
    if (sm_req_valid && sm_req_ready) begin
      pend_v[sm_tag]   = 1;
      pend_due[sm_tag] = cyc + int'($urandom_range(1, dly_max));
      pend_d[sm_tag]   = clmul12(half(cur_a, exp_tag >= 2), half(cur_b, (exp_tag % 2) == 1));
      log_tag.push_back(sm_tag); log_a.push_back(sm_a); log_b.push_back(sm_b);
      exp_tag++;
    end
    if (sm_rsp_valid) pend_v[sm_rsp_tag] = 0;
    if (out_valid) begin
      seen_out = 1;
      check("out_expected", 64'(exp_have), 64'd1);
      check("p_out", 64'(p_out), 64'(exp_p));
    end
    if (out_valid && out_ready) begin exp_have = 0; n_done++; end
    if (in_valid && in_ready) begin
      cur_a = a_in; cur_b = b_in; exp_p = clmul24(a_in, b_in); exp_have = 1; exp_tag = 0;
    end
  endtask

  task automatic tick();
    #1;
    compare_cycle();
    @(posedge clk);
    #1;
    cyc++;
    sm_rsp_valid = 0; sm_rsp_tag = 2'd0; sm_rsp_data = 23'd0;
    begin
      int cand[$];
      for (int t = 0; t < 4; t++)
        if (pend_v[t] && pend_due[t] <= cyc && !hold_mask[t]) cand.push_back(t);
      if (cand.size() > 0) begin
        int k;
        k = cand[$urandom_range(0, cand.size() - 1)];
        sm_rsp_valid = 1; sm_rsp_tag = 2'(k); sm_rsp_data = pend_d[k];
      end
    end
    if (rnd_mode) begin
      sm_req_ready = ($urandom_range(0, 9) < 7);
      out_ready    = ($urandom_range(0, 9) < 6);
      in_valid     = 1'($urandom_range(0, 1));
      a_in         = 24'($urandom);
      b_in         = 24'($urandom);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic start_op(input logic [23:0] a, input logic [23:0] b);
    int k = 0;
    while (!in_ready && k < 100) begin tick(); k++; end
    check("start_in_ready", 64'(in_ready), 64'd1);
    log_tag.delete(); log_a.delete(); log_b.delete();
    in_valid = 1; a_in = a; b_in = b;
    tick();
    in_valid = 0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    check("out_valid_arrived", 64'(out_valid), 64'd1);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    check({nm, "_req_valid"}, 64'(sm_req_valid), 64'd0);
    check({nm, "_req_fields"}, 64'({sm_a, sm_b, sm_tag}), 64'd0);
    check({nm, "_out_valid"}, 64'(out_valid), 64'd0);
    check({nm, "_p_out"}, 64'(p_out), 64'd0);
    check({nm, "_busy"}, 64'(busy), 64'd0);
    check({nm, "_errs"}, 64'({err_dup, err_tmo}), 64'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, k;
    logic [23:0] ra, rb;
    logic [22:0] d1;
    rst_n = 0; in_valid = 0; a_in = '0; b_in = '0; sm_req_ready = 1;
    sm_rsp_valid = 0; sm_rsp_tag = '0; sm_rsp_data = '0; out_ready = 1;
    for (int t = 0; t < 4; t++) pend_v[t] = 0;
    @(negedge clk);
    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1;
    tick();

    // x^0+x^1 squared, 1-cycle sub-multiplier
    start_op(24'h000003, 24'h000003);
    wait_out(lat);
    check("t1_latency", 64'(lat), 64'd6);
    check("t1_p_out", 64'(p_out), 64'h5);
    check("t1_nreq", 64'(log_tag.size()), 64'd4);
    if (log_tag.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        check("t1_req_tag", 64'(log_tag[i]), 64'(i));
        check("t1_req_ab", 64'({log_a[i], log_b[i]}), 64'h001001);
      end
    tick();

    start_op(24'h800000, 24'h800000);
    wait_out(lat);
    check("t2_p_out", 64'(p_out), 64'h4000_0000_0000);
    if (log_tag.size() >= 4) begin
      check("t2_tag3", 64'(log_tag[3]), 64'd3);
      check("t2_tag3_ab", 64'({log_a[3], log_b[3]}), 64'h800800);
    end
    tick();

    // Random traffic with stalls and out-of-order responses
    rnd_mode = 1; dly_max = 3; n_done = 0;
    for (int c = 0; c < 30000 && n_done < 200; c++) tick();
    rnd_mode = 0; in_valid = 0; sm_req_ready = 1; out_ready = 1;
    k = 0;
    while (busy && k < 200) begin tick(); k++; end
    check("rand_drained", 64'(busy), 64'd0);
    check("rand_ops_done", 64'(n_done >= 200), 64'd1);
    dly_max = 1;

    // Duplicate tag1 response with different data
    do_reset();
    check("dup_clean", 64'(err_dup), 64'd0);
    ra = 24'($urandom); rb = 24'($urandom);
    d1 = clmul12(half(ra, 0), half(rb, 1));
    hold_mask = 4'b0010;
    start_op(ra, rb);
    tick(); tick();
    sm_rsp_valid = 1; sm_rsp_tag = 2'd1; sm_rsp_data = d1;
    tick();
    check("dup_first_ok", 64'(err_dup), 64'd0);
    sm_rsp_valid = 1; sm_rsp_tag = 2'd1; sm_rsp_data = d1 ^ 23'h155;
    wait_out(lat);
    check("dup_err", 64'(err_dup), 64'd1);
    check("dup_p_first_data", 64'(p_out), 64'(clmul24(ra, rb)));
    hold_mask = 4'd0;
    tick();

    // Response while idle
    do_reset();
    check("idle_rsp_clean", 64'(err_dup), 64'd0);
    sm_rsp_valid = 1; sm_rsp_tag = 2'd0; sm_rsp_data = 23'h1234;
    tick();
    check("idle_rsp_err", 64'(err_dup), 64'd1);
    check("idle_rsp_state", 64'({in_ready, busy, out_valid, sm_req_valid}), 64'b1000);

    // Watchdog with tag2 withheld
    do_reset();
    hold_mask = 4'b0100; seen_out = 0;
    start_op(24'($urandom), 24'($urandom));
    for (int i = 0; i < 12; i++) tick();
    check("tmo_not_early", 64'(err_tmo), 64'd0);
    k = 0;
    while (!err_tmo && k < 4) begin tick(); k++; end
    check("tmo_fired", 64'(err_tmo), 64'd1);
    check("tmo_idle", 64'({in_ready, busy}), 64'b10);
    check("tmo_no_out", 64'(seen_out || out_valid), 64'd0);
    pend_v[2] = 0; hold_mask = 4'd0;
    tick();

    // Reset mid-issue at ic=2
    do_reset();
    start_op(24'($urandom), 24'($urandom));
    tick(); tick();
    check("rst_mid_tag", 64'({sm_req_valid, sm_tag}), 64'b110);
    rst_n = 0;
    tick();
    rst_n = 1;
    check_reset_outputs("rst_mid");
    sm_rsp_valid = 1; sm_rsp_tag = 2'd2; sm_rsp_data = 23'h7;
    tick();
    check("rst_stale_rsp_err", 64'(err_dup), 64'd1);
    start_op(24'h000001, 24'h000001);
    wait_out(lat);
    check("rst_after_p_out", 64'(p_out), 64'h1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
